// File: rtl/usb_tx_encoder_if.sv
// Transmit-side bus between the host/tx FIFO and the USB full-speed encoder.
// USB_TX_ABORT_EN adds the tx_abort request line.
interface usb_tx_encoder_if;
  logic       tx_start;
  logic [3:0] tx_pid;
  logic       fifo_empty;
  logic [7:0] fifo_rdata;
  logic       fifo_renable;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;
  logic       dplus_out;
  logic       dminus_out;
`ifdef USB_TX_ABORT_EN
  logic       tx_abort;
`endif

  modport master (
`ifdef USB_TX_ABORT_EN
    output tx_abort,
`endif
    output tx_start, tx_pid, fifo_empty, fifo_rdata,
    input  fifo_renable, tx_busy, tx_done, tx_error, dplus_out, dminus_out
  );

  modport slave (
`ifdef USB_TX_ABORT_EN
    input  tx_abort,
`endif
    input  tx_start, tx_pid, fifo_empty, fifo_rdata,
    output fifo_renable, tx_busy, tx_done, tx_error, dplus_out, dminus_out
  );
endinterface

// File: rtl/usb_tx_encoder.sv
// USB full-speed packet transmitter: SYNC/PID/payload/CRC16/EOP framing with bit stuffing and NRZI.
// Optional USB_TX_ABORT_EN: tx_abort ends the packet with a bit-stuff violation and an error completion.
module usb_tx_encoder #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned MAX_BYTES    = 64
) (
  input  logic              clk,
  input  logic              rst,
  usb_tx_encoder_if.slave   bus
);
  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(MAX_BYTES + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SYNC, ST_PID, ST_DATA, ST_CRC, ST_EOP_SE0, ST_EOP_J, ST_ABORT
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [15:0]     sh_q, sh_d;
  logic [2:0]      ones_q, ones_d;
  logic [15:0]     crc_q, crc_d;
  logic [BW-1:0]   bytes_q, bytes_d;
  logic [3:0]      pid_q, pid_d;
  logic            abort_q, abort_d;
  logic            dp_q, dp_d, dm_q, dm_d;
  logic            ren_q, ren_d, busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic            bnd, stuffed, field_end, byte_ok, send, sbit, lvl, abort_in;
  logic [2:0]      ones_base;
  logic [15:0]     crc_tx;

`ifdef USB_TX_ABORT_EN
  assign abort_in = bus.tx_abort;
`else
  assign abort_in = 1'b0;
`endif

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = {r[14:0], 1'b0} ^ ((d[i] ^ r[15]) ? 16'h8005 : 16'h0000);
    end
    return r;
  endfunction

  function automatic logic [15:0] rev16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

  // Next-state and next-output logic; a bit is launched only at a bit boundary
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    ones_d    = ones_q;
    crc_d     = crc_q;
    bytes_d   = bytes_q;
    pid_d     = pid_q;
    abort_d   = abort_q;
    dp_d      = dp_q;
    dm_d      = dm_q;
    ren_d     = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    send      = 1'b0;
    sbit      = 1'b0;
    lvl       = dp_q;
    ones_base = ones_q;
    crc_tx    = rev16(~crc_q);
    bnd       = (timer_q == TW'(CLKS_PER_BIT - 1));
    stuffed   = (state_q inside {ST_SYNC, ST_PID, ST_DATA, ST_CRC});
    field_end = (cnt_q == ((state_q == ST_CRC) ? 4'd15 : 4'd7));
    byte_ok   = !bus.fifo_empty && (bytes_q < BW'(MAX_BYTES));

    if (state_q != ST_IDLE) timer_d = bnd ? '0 : timer_q + 1'b1;
    if (stuffed && abort_in) abort_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (bus.tx_start) begin
          if (bus.tx_pid[1]) begin
            state_d   = ST_SYNC;
            pid_d     = bus.tx_pid;
            busy_d    = 1'b1;
            timer_d   = '0;
            cnt_d     = '0;
            sh_d      = 16'h0040;
            crc_d     = 16'hFFFF;
            bytes_d   = '0;
            abort_d   = 1'b0;
            lvl       = 1'b1;
            ones_base = '0;
            send      = 1'b1;
            sbit      = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_SYNC, ST_PID, ST_DATA, ST_CRC: begin
        if (bnd) begin
          send = 1'b1;
          if (abort_q || abort_in) begin
            // Abort: hold the line (NRZI ones) without stuffing
            state_d = ST_ABORT;
            cnt_d   = '0;
            send    = 1'b0;
          end else if (ones_q == 3'd6) begin
            sbit = 1'b0;
          end else if (!field_end) begin
            sbit  = sh_q[0];
            sh_d  = sh_q >> 1;
            cnt_d = cnt_q + 1'b1;
          end else begin
            cnt_d = '0;
            if (state_q == ST_SYNC) begin
              state_d = ST_PID;
              sbit    = pid_q[0];
              sh_d    = 16'({~pid_q, pid_q} >> 1);
            end else if (state_q == ST_CRC || (state_q == ST_PID && !pid_q[0])) begin
              state_d = ST_EOP_SE0;
              send    = 1'b0;
              dp_d    = 1'b0;
              dm_d    = 1'b0;
            end else if (byte_ok) begin
              state_d = ST_DATA;
              ren_d   = 1'b1;
              bytes_d = bytes_q + 1'b1;
              crc_d   = crc_byte(crc_q, bus.fifo_rdata);
              sbit    = bus.fifo_rdata[0];
              sh_d    = 16'(bus.fifo_rdata >> 1);
            end else begin
              state_d = ST_CRC;
              sbit    = crc_tx[0];
              sh_d    = crc_tx >> 1;
            end
          end
        end
      end
      ST_ABORT: begin
        if (bnd) begin
          if (cnt_q != 4'd7) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            state_d = ST_EOP_SE0;
            cnt_d   = '0;
            dp_d    = 1'b0;
            dm_d    = 1'b0;
          end
        end
      end
      ST_EOP_SE0: begin
        if (bnd) begin
          if (cnt_q == 4'd0) begin
            cnt_d = 4'd1;
          end else begin
            state_d = ST_EOP_J;
            dp_d    = 1'b1;
            dm_d    = 1'b0;
          end
        end
      end
      ST_EOP_J: begin
        if (bnd) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = abort_q;
          abort_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // NRZI: a 0 toggles the line, a 1 holds it
    if (send) begin
      dp_d   = sbit ? lvl : ~lvl;
      dm_d   = ~dp_d;
      ones_d = sbit ? ones_base + 3'd1 : 3'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
      ones_q  <= '0;
      crc_q   <= 16'hFFFF;
      bytes_q <= '0;
      pid_q   <= '0;
      abort_q <= 1'b0;
      dp_q    <= 1'b1;
      dm_q    <= 1'b0;
      ren_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      ones_q  <= ones_d;
      crc_q   <= crc_d;
      bytes_q <= bytes_d;
      pid_q   <= pid_d;
      abort_q <= abort_d;
      dp_q    <= dp_d;
      dm_q    <= dm_d;
      ren_q   <= ren_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.fifo_renable = ren_q;
  assign bus.tx_busy      = busy_q;
  assign bus.tx_done      = done_q;
  assign bus.tx_error     = err_q;
  assign bus.dplus_out    = dp_q;
  assign bus.dminus_out   = dm_q;
endmodule

// File: tb/tb_usb_tx_encoder.sv
// Scoreboard bench for usb_tx_encoder: expected line symbols are queued at tx_start and
// popped one per bit time; data packets are also decoded back and CRC-residual checked.
module tb_usb_tx_encoder;
  localparam int unsigned CPB  = 4;
  localparam int unsigned MAXB = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  usb_tx_encoder_if bus();

  usb_tx_encoder #(.CLKS_PER_BIT(CPB), .MAX_BYTES(MAXB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned pops        = 0;

  logic [7:0] fifo_q[$];
  logic [1:0] exp_q[$];
  logic [7:0] pay_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void sync_fifo();
    bus.fifo_empty = (fifo_q.size() == 0);
    bus.fifo_rdata = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
  endfunction

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic d);
    return {c[14:0], 1'b0} ^ ((d ^ c[15]) ? 16'h8005 : 16'h0000);
  endfunction

  // One clock: sample at the falling edge and model the FIFO pop
  task automatic tick();
    @(negedge clk);
    chk("renable_while_empty", 32'(bus.fifo_renable & bus.fifo_empty), 0);
    if (bus.fifo_renable === 1'b1 && fifo_q.size() != 0) begin
      pops++;
      void'(fifo_q.pop_front());
    end
    sync_fifo();
  endtask

  // Reference model: raw bits -> stuffing -> NRZI -> line symbols {D+,D-}
  task automatic build_expected(input logic [3:0] pid);
    logic        bq[$];
    logic [7:0]  b;
    logic [7:0]  pb;
    logic [15:0] crc;
    int          n, ones;
    logic        lvl;
    exp_q.delete();
    pay_q.delete();
    b  = 8'h80;
    for (int j = 0; j < 8; j++) bq.push_back(b[j]);
    pb = {~pid, pid};
    for (int j = 0; j < 8; j++) bq.push_back(pb[j]);
    if (pid[1:0] == 2'b11) begin
      n   = (fifo_q.size() < MAXB) ? fifo_q.size() : MAXB;
      crc = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
        b = fifo_q[i];
        pay_q.push_back(b);
        for (int j = 0; j < 8; j++) begin
          bq.push_back(b[j]);
          crc = crc_step(crc, b[j]);
        end
      end
      for (int j = 15; j >= 0; j--) bq.push_back(~crc[j]);
    end
    ones = 0;
    lvl  = 1'b1;
    foreach (bq[i]) begin
      lvl = bq[i] ? lvl : ~lvl;
      exp_q.push_back({lvl, ~lvl});
      ones = bq[i] ? ones + 1 : 0;
      if (ones == 6) begin
        lvl  = ~lvl;
        exp_q.push_back({lvl, ~lvl});
        ones = 0;
      end
    end
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b10);
  endtask

  task automatic run_packet(input logic [3:0] pid, input int glitch, output int stuffs);
    int          c, pops0, fifo0, exp_pops, ones;
    logic [1:0]  sym;
    logic [1:0]  lv[$];
    logic        dec[$];
    logic        prev, d;
    logic [15:0] crc;
    stuffs = 0;
    build_expected(pid);
    exp_pops = pay_q.size();
    pops0    = pops;
    fifo0    = fifo_q.size();
    sym      = 2'b10;
    bus.tx_pid   = pid;
    bus.tx_start = 1'b1;
    tick();
    bus.tx_start = 1'b0;
    c = 0;
    forever begin
      if (c % CPB == 0) begin
        if (exp_q.size() == 0) break;
        sym = exp_q.pop_front();
        lv.push_back({bus.dplus_out, bus.dminus_out});
      end
      chk("line", 32'({bus.dplus_out, bus.dminus_out}), 32'(sym));
      chk("busy", 32'(bus.tx_busy), 1);
      chk("done_early", 32'(bus.tx_done), 0);
      bus.tx_start = (c == glitch);
      if (c == glitch) bus.tx_pid = 4'b0010;
      tick();
      c++;
    end
    chk("busy_end", 32'(bus.tx_busy), 0);
    chk("done_pulse", 32'(bus.tx_done), 1);
    chk("error_end", 32'(bus.tx_error), 0);
    chk("line_idle", 32'({bus.dplus_out, bus.dminus_out}), 2'b10);
    chk("pop_count", pops - pops0, exp_pops);
    chk("fifo_left", fifo_q.size(), fifo0 - exp_pops);
    tick();
    chk("done_once", 32'(bus.tx_done), 0);
    if (pid[1:0] == 2'b11) begin
      prev = 1'b1;
      ones = 0;
      foreach (lv[i]) begin
        if (lv[i] == 2'b00) break;
        d    = (lv[i][1] == prev);
        prev = lv[i][1];
        if (ones == 6) begin
          ones = 0;
          if (dec.size() > 16 && dec.size() <= 16 + 8 * pay_q.size()) stuffs++;
        end else begin
          dec.push_back(d);
          ones = d ? ones + 1 : 0;
        end
      end
      crc = 16'hFFFF;
      for (int i = 16; i < dec.size(); i++) crc = crc_step(crc, dec[i]);
      chk("crc_residual", 32'(crc), 32'h800D);
      chk("decoded_len", dec.size(), 32 + 8 * pay_q.size());
    end
  endtask

  int st;

  initial begin
    bus.tx_start = 1'b0;
    bus.tx_pid   = 4'h0;
`ifdef USB_TX_ABORT_EN
    bus.tx_abort = 1'b0;
`endif
    sync_fifo();
    repeat (3) @(negedge clk);
    chk("reset_state", 32'({bus.dplus_out, bus.dminus_out, bus.tx_busy,
                            bus.fifo_renable, bus.tx_done, bus.tx_error}), 6'b100000);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("idle", 32'({bus.dplus_out, bus.dminus_out, bus.tx_busy,
                       bus.fifo_renable, bus.tx_done, bus.tx_error}), 6'b100000);
    end

    // ACK handshake, DATA0 empty
    run_packet(4'b0010, -1, st);
    run_packet(4'b0011, -1, st);

    // DATA1 with two 0xFF bytes: two stuffed bits inside the payload
    fifo_q.push_back(8'hFF);
    fifo_q.push_back(8'hFF);
    sync_fifo();
    run_packet(4'b1011, -1, st);
    chk("payload_stuffs", st, 2);

    // DATA1 with mixed bytes
    fifo_q.push_back(8'h00);
    fifo_q.push_back(8'h7E);
    fifo_q.push_back(8'hA5);
    sync_fifo();
    run_packet(4'b1011, -1, st);

    // 70 bytes: only MAX_BYTES leave, stray tx_start mid-packet ignored
    for (int i = 0; i < 70; i++) fifo_q.push_back(8'($urandom));
    sync_fifo();
    run_packet(4'b0011, 200, st);
    chk("fifo_remaining", fifo_q.size(), 6);
    fifo_q.delete();
    sync_fifo();

    // Illegal token PID
    bus.tx_pid   = 4'b0001;
    bus.tx_start = 1'b1;
    tick();
    bus.tx_start = 1'b0;
    chk("token_error", 32'(bus.tx_error), 1);
    chk("token_busy", 32'(bus.tx_busy), 0);
    tick();
    chk("token_error_once", 32'(bus.tx_error), 0);
    for (int i = 0; i < 20; i++) begin
      chk("token_idle", 32'({bus.dplus_out, bus.dminus_out, bus.tx_busy}), 3'b100);
      tick();
    end

    // Reset in the middle of DATA
    for (int i = 0; i < 10; i++) fifo_q.push_back(8'(i * 17 + 3));
    sync_fifo();
    bus.tx_pid   = 4'b0011;
    bus.tx_start = 1'b1;
    tick();
    bus.tx_start = 1'b0;
    repeat (20 * CPB) tick();
    chk("mid_busy", 32'(bus.tx_busy), 1);
    chk("mid_pops", fifo_q.size(), 9);
    #2 rst = 1'b1;
    #1;
    chk("async_reset", 32'({bus.dplus_out, bus.dminus_out, bus.tx_busy, bus.fifo_renable}), 4'b1000);
    repeat (10) tick();
    rst = 1'b0;
    repeat (20) tick();
    chk("reset_no_pops", fifo_q.size(), 9);
    chk("reset_idle", 32'({bus.dplus_out, bus.dminus_out, bus.tx_busy}), 3'b100);
    fifo_q.delete();
    sync_fifo();

    // Recovery after reset
    fifo_q.push_back(8'h3C);
    fifo_q.push_back(8'hC3);
    fifo_q.push_back(8'h01);
    sync_fifo();
    run_packet(4'b0011, -1, st);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/usb_tx_encoder.md
Name: usb_tx_encoder

Overview:
USB full-speed packet transmitter; the transmit-side counterpart of the receiver FIFO path. Pulls payload bytes from a transmit FIFO and frames them into SYNC, PID, payload, CRC16 and EOP. Applies bit stuffing and NRZI encoding, then drives the D+/D- line outputs. Sits between the tx FIFO and the USB pad drivers.

Parameters:
CLKS_PER_BIT, 4, system clocks per USB bit time (48 MHz clk, 12 Mbps); legal values ≥2
MAX_BYTES, 64, maximum payload bytes per data packet

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
tx_start  input  1  one-cycle request to send a packet; sampled only in IDLE
tx_pid  input  4  PID nibble, latched on accepted tx_start
fifo_empty  input  1  tx FIFO empty flag
fifo_rdata  input  8  tx FIFO head byte, valid while fifo_empty=0
fifo_renable  output  1  one-cycle pop of the tx FIFO
tx_busy  output  1  high from accepted tx_start through the end of EOP
tx_done  output  1  one-cycle pulse at packet completion
tx_error  output  1  one-cycle pulse on an illegal PID request
dplus_out  output  1  D+ line, registered
dminus_out  output  1  D- line, registered

Behaviour:
- Clocking and reset: one clock (clk); reset rst is asynchronous and active-high. Reset values: dplus_out=1, dminus_out=0 (J/idle); fifo_renable, tx_busy, tx_done and tx_error all 0; state IDLE. Reset mid-packet abandons the packet immediately and does not pop the FIFO.
- Bit timer: counts 0..CLKS_PER_BIT-1. Exactly one bit is launched per bit time. Line outputs change only at bit boundaries.
- PID legality:
  - Data PID (tx_pid[1:0]=2'b11): sends payload and CRC16.
  - Handshake PID (tx_pid[1:0]=2'b10): sends PID only.
  - Any other PID: tx_error pulses in the cycle after tx_start; the block stays IDLE and sends nothing.
- States: IDLE -> SYNC -> PID -> (DATA -> CRC) -> EOP_SE0 -> EOP_J -> IDLE.
  - Latency: first SYNC bit appears on the line in the cycle after the accepted tx_start; tx_busy rises in that same cycle.
  - SYNC: 8 bits, 0x80, LSB first (seven 0s then a 1).
  - PID: byte {~tx_pid, tx_pid}, LSB first.
  - DATA: at each byte boundary, if fifo_empty=0 and fewer than MAX_BYTES bytes have been sent, capture fifo_rdata and pulse fifo_renable for exactly one cycle. Otherwise go to CRC. A zero-length payload is legal. Bytes beyond MAX_BYTES stay in the FIFO.
  - CRC: CRC16, polynomial x^16+x^15+x^2+1, init 0xFFFF, updated per payload bit LSB-first. Transmit the complemented register, bit 15 first, 16 bits.
  - EOP_SE0: both lines 0 for 2 bit times.
  - EOP_J: D+=1, D-=0 for 1 bit time. At exit, tx_done pulses and tx_busy falls in the same cycle.
- Bit stuffing: applies from the first SYNC bit through the last CRC bit. After six consecutive 1 data bits, insert one 0 bit. The stuffed bit consumes a full bit time and resets the ones count. Stuffing never occurs in EOP. The ones count clears when entering SYNC.
- NRZI: data 0 toggles the line; data 1 holds it. Line state starts at J on entry to SYNC. Differential output: dminus_out = ~dplus_out outside EOP_SE0.
- tx_start while tx_busy=1 is ignored, with no side effects.
- fifo_renable is never asserted while fifo_empty=1.

Optional Feature:
USB_TX_ABORT_EN
- Defined: adds input port tx_abort (1 bit). tx_abort=1 during SYNC, PID, DATA or CRC ends the current field at the next bit boundary. The block then sends 8 NRZI-encoded 1 bits with stuffing disabled (bit-stuff violation), followed by normal EOP. tx_done and tx_error pulse together at completion. No further FIFO pops occur. tx_abort is ignored in IDLE and EOP states.
- Undefined: no tx_abort port; packets always run to completion.

Test Plan:
- Reset held, then released: dplus_out=1, dminus_out=0, tx_busy=0, no fifo_renable, for 100 cycles idle.
- tx_start with tx_pid=4'b0010 (ACK): line shows SYNC, then PID 0xD2 NRZI-encoded, then 2 bit times SE0 and 1 J. tx_done pulses once, no FIFO pops, total 19 bit times × CLKS_PER_BIT cycles.
- tx_start with tx_pid=4'b0011 (DATA0) and FIFO empty: PID 0xC3, then CRC field 0x0000 on the wire, then EOP. Zero fifo_renable pulses.
- DATA1 with FIFO holding 0xFF,0xFF: exactly 2 fifo_renable pulses. A stuffed 0 appears after every six consecutive 1s (2 stuffed bits within the payload). Decoded CRC residual checks as 0x800D.
- FIFO holding 70 bytes, DATA0: exactly 64 pops, then CRC and EOP; 6 bytes remain in the FIFO. tx_start pulsed mid-packet is ignored.
- tx_pid=4'b0001 (token): tx_error pulses once, tx_busy stays 0, line stays J. rst asserted mid-DATA: line returns to J asynchronously, no further pops.
